readout_rx_state_decision_unit_mux: RTL and testbench

- Next-generation readout state discriminator for frequency-multiplexed readout: NUM_CHANNELS independent qubit channels, each with an integration window, a saturating I/Q accumulator and a two-line linear classifier.
- Produces a 2-bit result per channel: 0 = |0>, 1 = |1>, 2 = leaked when three-state mode is enabled.
- Sits after the demodulator/filter chain and drives the measurement-result bus through a per-channel valid/ready handshake.

---
 rtl/readout_rx_mux_pkg.sv | 20 ++
 rtl/readout_rx_channel_discriminator.sv | 152 +++++++++++++++
 rtl/readout_rx_state_decision_unit_mux.sv | 90 +++++++++
 tb/tb_readout_rx_state_decision_unit_mux.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_rx_mux_pkg.sv
// Shared constants for the multiplexed readout state discriminator:
// coefficient slot indices, result encodings and the per-channel FSM states.
package readout_rx_mux_pkg;

    localparam logic [1:0] IDX_SLOPE_A     = 2'd0;
    localparam logic [1:0] IDX_INTERCEPT_A = 2'd1;
    localparam logic [1:0] IDX_SLOPE_B     = 2'd2;
    localparam logic [1:0] IDX_INTERCEPT_B = 2'd3;

    localparam logic [1:0] RES_0    = 2'd0;
    localparam logic [1:0] RES_1    = 2'd1;
    localparam logic [1:0] RES_LEAK = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_CLASSIFY = 2'd2
    } ch_state_t;

endpackage

// File: rtl/readout_rx_channel_discriminator.sv
// One readout channel: integration-window FSM, saturating I/Q accumulator,
// two-line linear classifier and the valid/ready result register.
module readout_rx_channel_discriminator
    import readout_rx_mux_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int ACCUMULATOR_WIDTH = 18,
    parameter int COEFF_WIDTH       = 8,
    parameter int SLOPE_FRAC        = 7,
    parameter int INTERCEPT_SHIFT   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [COEFF_WIDTH-1:0] i_slope_a,
    input  logic signed [COEFF_WIDTH-1:0] i_intercept_a,
    input  logic signed [COEFF_WIDTH-1:0] i_slope_b,
    input  logic signed [COEFF_WIDTH-1:0] i_intercept_b,
    input  logic                          i_three_state_en,
    input  logic                          i_start,
    input  logic                          i_finish,
    input  logic                          i_valid,
    input  logic signed [DATA_WIDTH-1:0]  i_i,
    input  logic signed [DATA_WIDTH-1:0]  i_q,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [1:0]                    o_result,
    output logic                          o_sat,
    output logic                          o_overrun
);

    localparam int AW = ACCUMULATOR_WIDTH;
    localparam int PW = ACCUMULATOR_WIDTH + COEFF_WIDTH + SLOPE_FRAC + INTERCEPT_SHIFT + 1;
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    ch_state_t               r_state;
    logic                    r_pend;
    logic signed [AW-1:0]    r_sum_i, r_sum_q;
    logic                    r_sat;
    logic signed [AW-1:0]    r_fin_i, r_fin_q;
    logic                    r_fin_sat;
    logic                    r_valid, r_res_sat, r_overrun;
    logic [1:0]              r_result;

    logic signed [AW-1:0]    w_add_i, w_add_q, w_load_i, w_load_q;
    logic                    w_ovf_i, w_ovf_q, w_open;
    logic signed [PW-1:0]    w_lhs, w_rhs_a, w_rhs_b;
    logic [1:0]              w_decision;

    // Returns {overflow, clamped sum}.
    function automatic logic [AW:0] sat_add(input logic signed [AW-1:0] a,
                                            input logic signed [DATA_WIDTH-1:0] b);
        logic signed [AW:0] s;
        s = (AW+1)'(a) + (AW+1)'(b);
        if (s[AW] != s[AW-1])
            return s[AW] ? {1'b1, ACC_MIN} : {1'b1, ACC_MAX};
        return {1'b0, s[AW-1:0]};
    endfunction

    always_comb begin
        {w_ovf_i, w_add_i} = {1'b0, r_sum_i};
        {w_ovf_q, w_add_q} = {1'b0, r_sum_q};
        if (i_valid) begin
            {w_ovf_i, w_add_i} = sat_add(r_sum_i, i_i);
            {w_ovf_q, w_add_q} = sat_add(r_sum_q, i_q);
        end
    end

    assign w_load_i = i_valid ? AW'(i_i) : '0;
    assign w_load_q = i_valid ? AW'(i_q) : '0;

    // A window reopened by start+finish stays live while the old one classifies.
    assign w_open = (r_state == ST_ACCUM) || ((r_state == ST_CLASSIFY) && r_pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pend    <= 1'b0;
            r_sum_i   <= '0;
            r_sum_q   <= '0;
            r_sat     <= 1'b0;
            r_fin_i   <= '0;
            r_fin_q   <= '0;
            r_fin_sat <= 1'b0;
        end else if (w_open && i_finish) begin
            r_fin_i   <= w_add_i;
            r_fin_q   <= w_add_q;
            r_fin_sat <= r_sat | w_ovf_i | w_ovf_q;
            r_state   <= ST_CLASSIFY;
            r_pend    <= i_start;
            r_sum_i   <= '0;
            r_sum_q   <= '0;
            r_sat     <= 1'b0;
        end else if (i_start) begin
            r_state   <= ST_ACCUM;
            r_pend    <= 1'b0;
            r_sum_i   <= w_load_i;
            r_sum_q   <= w_load_q;
            r_sat     <= 1'b0;
        end else if (w_open) begin
            r_state   <= ST_ACCUM;
            r_pend    <= 1'b0;
            r_sum_i   <= w_add_i;
            r_sum_q   <= w_add_q;
            r_sat     <= r_sat | w_ovf_i | w_ovf_q;
        end else begin
            r_state   <= ST_IDLE;
            r_pend    <= 1'b0;
            r_sum_i   <= w_load_i;
            r_sum_q   <= w_load_q;
            r_sat     <= 1'b0;
        end
    end

    // Full-width products from the frozen window sums; the decision is what gets registered.
    assign w_lhs   = PW'(r_fin_q) <<< SLOPE_FRAC;
    assign w_rhs_a = PW'(i_slope_a) * PW'(r_fin_i)
                   + (PW'(i_intercept_a) <<< (SLOPE_FRAC + INTERCEPT_SHIFT));
    assign w_rhs_b = PW'(i_slope_b) * PW'(r_fin_i)
                   + (PW'(i_intercept_b) <<< (SLOPE_FRAC + INTERCEPT_SHIFT));

    always_comb begin
        w_decision = RES_0;
        if (i_three_state_en && (w_lhs > w_rhs_b))
            w_decision = RES_LEAK;
        else if (w_lhs > w_rhs_a)
            w_decision = RES_1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_result  <= RES_0;
            r_res_sat <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_state == ST_CLASSIFY) begin
            r_valid   <= 1'b1;
            r_result  <= w_decision;
            r_res_sat <= r_fin_sat;
            if (r_valid && !i_ready)
                r_overrun <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_result  = r_result;
    assign o_sat     = r_res_sat;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/readout_rx_state_decision_unit_mux.sv
// Frequency-multiplexed readout discriminator: per-channel coefficient
// register file plus one independent discriminator per qubit channel.
module readout_rx_state_decision_unit_mux
    import readout_rx_mux_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int NUM_CHANNELS      = 4,
    parameter int CH_WIDTH          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int ACCUMULATOR_WIDTH = DATA_WIDTH + 10,
    parameter int COEFF_WIDTH       = DATA_WIDTH,
    parameter int SLOPE_FRAC        = DATA_WIDTH - 1,
    parameter int INTERCEPT_SHIFT   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               coeff_wr_en,
    input  logic [CH_WIDTH+1:0]                coeff_wr_addr,
    input  logic [COEFF_WIDTH-1:0]             coeff_wr_data,
    input  logic [NUM_CHANNELS-1:0]            three_state_en,
    input  logic [NUM_CHANNELS-1:0]            start_count,
    input  logic [NUM_CHANNELS-1:0]            finish_count,
    input  logic [NUM_CHANNELS-1:0]            valid_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] q_in,
    output logic [NUM_CHANNELS-1:0]            meas_result_valid_out,
    input  logic [NUM_CHANNELS-1:0]            meas_result_ready_in,
    output logic [2*NUM_CHANNELS-1:0]          meas_result_out,
    output logic [NUM_CHANNELS-1:0]            sat_flag_out,
    output logic [NUM_CHANNELS-1:0]            overrun_flag_out
);

    logic [CH_WIDTH-1:0] w_wr_ch;
    logic [1:0]          w_wr_idx;

    assign w_wr_ch  = coeff_wr_addr[CH_WIDTH+1:2];
    assign w_wr_idx = coeff_wr_addr[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic signed [COEFF_WIDTH-1:0] r_slope_a, r_intercept_a, r_slope_b, r_intercept_b;
            logic                          w_sel;

            assign w_sel = coeff_wr_en && (w_wr_ch == CH_WIDTH'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_slope_a     <= '0;
                    r_intercept_a <= '0;
                    r_slope_b     <= '0;
                    r_intercept_b <= '0;
                end else if (w_sel) begin
                    case (w_wr_idx)
                        IDX_SLOPE_A:     r_slope_a     <= coeff_wr_data;
                        IDX_INTERCEPT_A: r_intercept_a <= coeff_wr_data;
                        IDX_SLOPE_B:     r_slope_b     <= coeff_wr_data;
                        default:         r_intercept_b <= coeff_wr_data;
                    endcase
                end
            end

            readout_rx_channel_discriminator #(
                .DATA_WIDTH        (DATA_WIDTH),
                .ACCUMULATOR_WIDTH (ACCUMULATOR_WIDTH),
                .COEFF_WIDTH       (COEFF_WIDTH),
                .SLOPE_FRAC        (SLOPE_FRAC),
                .INTERCEPT_SHIFT   (INTERCEPT_SHIFT)
            ) u_disc (
                .clk              (clk),
                .rst_n            (rst),
                .i_slope_a        (r_slope_a),
                .i_intercept_a    (r_intercept_a),
                .i_slope_b        (r_slope_b),
                .i_intercept_b    (r_intercept_b),
                .i_three_state_en (three_state_en[gi]),
                .i_start          (start_count[gi]),
                .i_finish         (finish_count[gi]),
                .i_valid          (valid_in[gi]),
                .i_i              (i_in[gi*DATA_WIDTH +: DATA_WIDTH]),
                .i_q              (q_in[gi*DATA_WIDTH +: DATA_WIDTH]),
                .i_ready          (meas_result_ready_in[gi]),
                .o_valid          (meas_result_valid_out[gi]),
                .o_result         (meas_result_out[2*gi +: 2]),
                .o_sat            (sat_flag_out[gi]),
                .o_overrun        (overrun_flag_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_readout_rx_state_decision_unit_mux.sv
// Directed and randomized checks of the readout discriminator against a
// window-level behavioural model (narrow 10-bit accumulator build).
module tb_readout_rx_state_decision_unit_mux;

    localparam int DW = 8;
    localparam int NCH = 4;
    localparam int AW = 10;
    localparam int SF = DW - 1;
    localparam int IS = 8;
    localparam int ACC_MAX = (1 << (AW - 1)) - 1;
    localparam int ACC_MIN = -(1 << (AW - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic coeff_wr_en = 1'b0;
    logic [3:0] coeff_wr_addr = '0;
    logic [7:0] coeff_wr_data = '0;
    logic [NCH-1:0] three_state_en = '0, start_count = '0, finish_count = '0;
    logic [NCH-1:0] valid_in = '0, ready = '0;
    logic [NCH*DW-1:0] i_in = '0, q_in = '0;
    logic [NCH-1:0] v_out, sat_out, ovr_out;
    logic [2*NCH-1:0] res_out;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    readout_rx_state_decision_unit_mux #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .ACCUMULATOR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr), .coeff_wr_data(coeff_wr_data),
        .three_state_en(three_state_en), .start_count(start_count), .finish_count(finish_count),
        .valid_in(valid_in), .i_in(i_in), .q_in(q_in),
        .meas_result_valid_out(v_out), .meas_result_ready_in(ready),
        .meas_result_out(res_out), .sat_flag_out(sat_out), .overrun_flag_out(ovr_out)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (window level) ----------------
    bit m_open[NCH];
    int m_si[NCH], m_sq[NCH];
    bit m_wsat[NCH];
    bit m_cls[NCH];
    int m_ci[NCH], m_cq[NCH];
    bit m_csat[NCH];
    bit m_valid[NCH], m_osat[NCH], m_ovr[NCH];
    int m_res[NCH];
    int m_coef[NCH][4];

    function automatic int samp(logic [NCH*DW-1:0] bus, int c);
        logic [DW-1:0] b;
        b = bus[c*DW +: DW];
        return int'($signed(b));
    endfunction

    function automatic int clamp(int v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < ACC_MIN) return ACC_MIN;
        return v;
    endfunction

    function automatic int classify(int c);
        longint lhs, ra, rb;
        lhs = longint'(m_cq[c]) * (longint'(1) << SF);
        ra = longint'(m_coef[c][0]) * longint'(m_ci[c]) + longint'(m_coef[c][1]) * (longint'(1) << (SF + IS));
        rb = longint'(m_coef[c][2]) * longint'(m_ci[c]) + longint'(m_coef[c][3]) * (longint'(1) << (SF + IS));
        if (three_state_en[c] && lhs > rb) return 2;
        if (lhs > ra) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_open[c] = 0; m_si[c] = 0; m_sq[c] = 0; m_wsat[c] = 0; m_cls[c] = 0;
            m_valid[c] = 0; m_osat[c] = 0; m_ovr[c] = 0; m_res[c] = 0;
            for (int k = 0; k < 4; k++) m_coef[c][k] = 0;
        end
    endtask

    task automatic model_step();
        int si, sq, ri, rq;
        bit s;
        for (int c = 0; c < NCH; c++) begin
            if (m_cls[c]) begin
                if (m_valid[c] && !ready[c]) m_ovr[c] = 1;
                if (m_valid[c] && ready[c])
                    $display("ch%0d accepted result %0d sat %0d", c, m_res[c], m_osat[c]);
                m_valid[c] = 1; m_res[c] = classify(c); m_osat[c] = m_csat[c]; m_cls[c] = 0;
            end else if (m_valid[c] && ready[c]) begin
                $display("ch%0d accepted result %0d sat %0d", c, m_res[c], m_osat[c]);
                m_valid[c] = 0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            si = valid_in[c] ? samp(i_in, c) : 0;
            sq = valid_in[c] ? samp(q_in, c) : 0;
            ri = clamp(m_si[c] + si);
            rq = clamp(m_sq[c] + sq);
            s = m_wsat[c] || (ri != m_si[c] + si) || (rq != m_sq[c] + sq);
            if (m_open[c] && finish_count[c]) begin
                m_cls[c] = 1; m_ci[c] = ri; m_cq[c] = rq; m_csat[c] = s;
                m_open[c] = start_count[c]; m_si[c] = 0; m_sq[c] = 0; m_wsat[c] = 0;
            end else if (start_count[c]) begin
                m_open[c] = 1; m_si[c] = si; m_sq[c] = sq; m_wsat[c] = 0;
            end else if (m_open[c]) begin
                m_si[c] = ri; m_sq[c] = rq; m_wsat[c] = s;
            end
        end
        if (coeff_wr_en) m_coef[coeff_wr_addr[3:2]][coeff_wr_addr[1:0]] = int'($signed(coeff_wr_data));
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && cmp_en) begin
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("ch%0d_valid", c), 32'(v_out[c]), 32'(m_valid[c]));
                check($sformatf("ch%0d_overrun", c), 32'(ovr_out[c]), 32'(m_ovr[c]));
                if (m_valid[c]) begin
                    check($sformatf("ch%0d_result", c), 32'(res_out[2*c +: 2]), 32'(m_res[c]));
                    check($sformatf("ch%0d_sat", c), 32'(sat_out[c]), 32'(m_osat[c]));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_sample(int c, int iv, int qv);
        logic [7:0] bi, bq;
        bi = iv[7:0];
        bq = qv[7:0];
        i_in[c*DW +: DW] = bi;
        q_in[c*DW +: DW] = bq;
    endtask

    task automatic wr_coef(int c, int idx, int val);
        logic [1:0] bc, bx;
        bc = c[1:0];
        bx = idx[1:0];
        coeff_wr_en = 1; coeff_wr_addr = {bc, bx}; coeff_wr_data = val[7:0];
        cyc();
        coeff_wr_en = 0;
    endtask

    // Leaves the bench at the negedge one cycle after the finish edge.
    task automatic run_window(int c, int n, int iv, int qv);
        start_count[c] = 1; cyc(); start_count[c] = 0;
        repeat (n) begin valid_in[c] = 1; set_sample(c, iv, qv); cyc(); end
        valid_in[c] = 0; finish_count[c] = 1; cyc(); finish_count[c] = 0;
    endtask

    task automatic expect_res(int c, int res, int sat, bit pre_idle);
        if (pre_idle) check($sformatf("ch%0d_lat1_valid", c), 32'(v_out[c]), 0);
        cyc();
        check($sformatf("ch%0d_lat2_valid", c), 32'(v_out[c]), 1);
        check($sformatf("ch%0d_lit_result", c), 32'(res_out[2*c +: 2]), 32'(res));
        check($sformatf("ch%0d_lit_sat", c), 32'(sat_out[c]), 32'(sat));
    endtask

    task automatic accept(int c);
        ready[c] = 1; cyc(); ready[c] = 0;
        check($sformatf("ch%0d_accept_valid", c), 32'(v_out[c]), 0);
    endtask

    initial begin
        repeat (3) cyc();
        check("rst_valid", 32'(v_out), 0);
        check("rst_result", 32'(res_out), 0);
        check("rst_sat", 32'(sat_out), 0);
        check("rst_overrun", 32'(ovr_out), 0);
        #2 rst = 1;
        cmp_en = 1;
        cyc();

        // basic window on ch0
        wr_coef(0, 0, 0); wr_coef(0, 1, 0);
        run_window(0, 4, 10, 5);   expect_res(0, 1, 0, 1); accept(0);
        run_window(0, 4, 10, -5);  expect_res(0, 0, 0, 1); accept(0);

        // leakage line on ch1: q_sum 300 > 256
        wr_coef(1, 2, 0); wr_coef(1, 3, 1);
        three_state_en[1] = 1;
        run_window(1, 30, 0, 10);  expect_res(1, 2, 0, 1); accept(1);
        three_state_en[1] = 0;
        run_window(1, 30, 0, 10);  expect_res(1, 1, 0, 1); accept(1);

        // saturation on ch2, then a clean window
        run_window(2, 10, 127, 0); expect_res(2, 0, 1, 1); accept(2);
        run_window(2, 1, 1, 0);    expect_res(2, 0, 0, 1); accept(2);

        // overrun on ch3
        run_window(3, 2, 1, 1);    expect_res(3, 1, 0, 1);
        run_window(3, 2, 1, -1);   expect_res(3, 0, 0, 0);
        check("ch3_overrun_set", 32'(ovr_out[3]), 1);
        accept(3);
        check("ch3_overrun_sticky", 32'(ovr_out[3]), 1);

        // ready coinciding with a new result on ch0 is not an overrun
        run_window(0, 2, 1, 1);    expect_res(0, 1, 0, 1);
        run_window(0, 1, 1, -1);
        ready[0] = 1; cyc();
        check("ch0_noovr_valid", 32'(v_out[0]), 1);
        check("ch0_noovr_result", 32'(res_out[1:0]), 0);
        check("ch0_noovr_overrun", 32'(ovr_out[0]), 0);
        cyc(); ready[0] = 0;
        check("ch0_noovr_drained", 32'(v_out[0]), 0);

        // simultaneous start+finish on ch2
        start_count[2] = 1; cyc(); start_count[2] = 0;
        valid_in[2] = 1; set_sample(2, 3, 3); cyc();
        start_count[2] = 1; finish_count[2] = 1; cyc();
        start_count[2] = 0; finish_count[2] = 0; set_sample(2, 0, -1); cyc();
        check("sf_first_valid", 32'(v_out[2]), 1);
        check("sf_first_result", 32'(res_out[5:4]), 1);
        valid_in[2] = 0; finish_count[2] = 1; ready[2] = 1; cyc();
        finish_count[2] = 0; ready[2] = 0;
        check("sf_gap_valid", 32'(v_out[2]), 0);
        cyc();
        check("sf_second_valid", 32'(v_out[2]), 1);
        check("sf_second_result", 32'(res_out[5:4]), 0);
        accept(2);

        // reset in the middle of a window
        start_count[0] = 1; cyc(); start_count[0] = 0;
        valid_in[0] = 1; set_sample(0, 5, 5); cyc(); cyc();
        #2 rst = 0;
        #1;
        check("midrst_valid", 32'(v_out), 0);
        check("midrst_result", 32'(res_out), 0);
        check("midrst_sat", 32'(sat_out), 0);
        check("midrst_overrun", 32'(ovr_out), 0);
        valid_in[0] = 0;
        cyc();
        #2 rst = 1;
        cyc();
        finish_count[0] = 1; cyc(); finish_count[0] = 0;
        cyc(); cyc();
        check("midrst_finish_ignored", 32'(v_out[0]), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                start_count[c] = ($urandom_range(0, 7) == 0);
                finish_count[c] = ($urandom_range(0, 5) == 0);
                valid_in[c] = ($urandom_range(0, 3) != 0);
                ready[c] = $urandom_range(0, 1) == 1;
                set_sample(c, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
                if ($urandom_range(0, 199) == 0) three_state_en[c] = ~three_state_en[c];
            end
            coeff_wr_en = ($urandom_range(0, 7) == 0);
            coeff_wr_addr = 4'($urandom_range(0, 15));
            coeff_wr_data = 8'($urandom_range(0, 255));
            cyc();
        end
        start_count = '0; finish_count = '0; valid_in = '0; coeff_wr_en = 0; ready = '1;
        repeat (5) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
